// File: rtl/gpc_popcount_accum_if.sv
// Stream bundle for the frame popcount accumulator: beat input side plus frame-result output side.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the beat side, out_valid/out_ready on the result side.
//
// Signals
//   in_valid / in_ready / in_data[IN_W] / in_last      beat stream into the accumulator
//   out_valid / out_ready / out_sum[CNT_W] /
//   out_beats[BEAT_W] / out_sat                         one result per frame
// Modports
//   master : the side producing beats and consuming results (e.g. a testbench)
//   slave  : the accumulator itself
interface gpc_popcount_accum_if #(
    parameter int IN_W   = 32,
    parameter int CNT_W  = 16,
    parameter int BEAT_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_sum;
    logic [BEAT_W-1:0] out_beats;
    logic              out_sat;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_beats, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_beats, out_sat
    );
endinterface

// File: rtl/gpc_popcount_accum.sv
// Streaming frame popcount: GPC compressor tree per beat, registered count, saturating per-frame total.
// Latency: last beat accepted -> result valid two clocks later; 1 beat/clk while unstalled.
// Backpressure: a finished frame waiting on a held result stalls stage P and drops in_ready.
//
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears every register
//   flush : synchronous discard of the partial frame (stage P + accumulator); pending result kept
//   bus   : slave side of gpc_popcount_accum_if (beat stream in, frame result out)
module gpc_popcount_accum #(
    parameter int IN_W   = 32,
    parameter int CNT_W  = 16,
    parameter int BEAT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    gpc_popcount_accum_if.slave   bus
);
    localparam int PC_W   = $clog2(IN_W + 1);
    localparam int IW_W   = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int CI_W   = (PC_W > 1) ? $clog2(PC_W) : 1;
    // Far more passes than the tree depth ever needs; finished columns just pass through.
    localparam int PASSES = IN_W + 2;

    function automatic logic [2:0] gpc7_3(input logic [6:0] x);
        logic [2:0] r;
        r = '0;
        for (int j = 0; j < 7; j++) r = r + {2'b00, x[j]};
        return r;
    endfunction

    function automatic logic [1:0] gpc3_2(input logic [2:0] x);
        return {1'b0, x[0]} + {1'b0, x[1]} + {1'b0, x[2]};
    endfunction

    function automatic logic gpc1_1(input logic x);
        return x;
    endfunction

    // Column-wise bit-heap reduction. Each pass covers every column with the widest cell that
    // fits: 7 bits -> gpc7_3, 2..3 bits -> gpc3_2 (zero padded so a height-2 column still
    // shrinks), 1 bit -> gpc1_1. Cell outputs land in columns c, c+1, c+2. Carries beyond the
    // top column are always zero because the total never exceeds IN_W < 2^PC_W.
    function automatic logic [PC_W-1:0] gpc_tree(input logic [IN_W-1:0] d);
        logic [IN_W-1:0] cur [PC_W];
        logic [IN_W-1:0] nxt [PC_W];
        int              hc  [PC_W];
        int              hn  [PC_W];
        logic [6:0]      g;
        logic [2:0]      y;
        logic [PC_W-1:0] res;
        int              i, n_in, n_out;
        for (int c = 0; c < PC_W; c++) begin
            cur[CI_W'(c)] = '0;
            hc[CI_W'(c)]  = 0;
        end
        cur[0] = d;
        hc[0]  = IN_W;
        for (int p = 0; p < PASSES; p++) begin
            for (int c = 0; c < PC_W; c++) begin
                nxt[CI_W'(c)] = '0;
                hn[CI_W'(c)]  = 0;
            end
            for (int c = 0; c < PC_W; c++) begin
                i = 0;
                while (i < hc[CI_W'(c)]) begin
                    n_in = (hc[CI_W'(c)] - i >= 7) ? 7 : (hc[CI_W'(c)] - i >= 2) ? 3 : 1;
                    g = '0;
                    for (int j = 0; j < 7; j++)
                        if (j < n_in && i + j < hc[CI_W'(c)])
                            g[j] = cur[CI_W'(c)][IW_W'(i + j)];
                    if (n_in == 7) begin
                        y     = gpc7_3(g);
                        n_out = 3;
                    end else if (n_in == 3) begin
                        y     = {1'b0, gpc3_2(g[2:0])};
                        n_out = 2;
                    end else begin
                        y     = {2'b00, gpc1_1(g[0])};
                        n_out = 1;
                    end
                    for (int k = 0; k < 3; k++) begin
                        if (k < n_out && c + k < PC_W && hn[CI_W'(c + k)] < IN_W) begin
                            nxt[CI_W'(c + k)][IW_W'(hn[CI_W'(c + k)])] = y[2'(k)];
                            hn[CI_W'(c + k)] = hn[CI_W'(c + k)] + 1;
                        end
                    end
                    i = i + n_in;
                end
            end
            for (int c = 0; c < PC_W; c++) begin
                cur[CI_W'(c)] = nxt[CI_W'(c)];
                hc[CI_W'(c)]  = hn[CI_W'(c)];
            end
        end
        res = '0;
        for (int c = 0; c < PC_W; c++) res[CI_W'(c)] = cur[CI_W'(c)][0];
        return res;
    endfunction

    // Stage P
    logic              p_valid;
    logic [PC_W-1:0]   p_cnt;
    logic              p_last;
    // Frame accumulator
    logic [CNT_W-1:0]  acc;
    logic [BEAT_W-1:0] beats;
    logic              sat;
    // Result registers
    logic              out_valid;
    logic [CNT_W-1:0]  out_sum;
    logic [BEAT_W-1:0] out_beats;
    logic              out_sat;

    logic              stall, in_ready, in_fire, out_fire, p_adv;
    logic [PC_W-1:0]   beat_cnt;
    logic [CNT_W:0]    s_wide;
    logic [BEAT_W:0]   b_wide;
    logic [CNT_W-1:0]  s_sat;
    logic [BEAT_W-1:0] b_sat;
    logic              ovf;

    // A completed frame sitting in P can only retire into the result register once the old
    // result leaves; until then P (and therefore the input) holds.
    assign stall    = p_valid && p_last && out_valid && !bus.out_ready;
    assign in_ready = !p_valid || !stall;
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid && bus.out_ready;
    assign p_adv    = p_valid && !stall;
    assign beat_cnt = gpc_tree(bus.in_data);

    always_comb begin
        s_wide = {1'b0, acc} + (CNT_W + 1)'(p_cnt);
        b_wide = {1'b0, beats} + (BEAT_W + 1)'(1);
        s_sat  = s_wide[CNT_W]  ? '1 : s_wide[CNT_W-1:0];
        b_sat  = b_wide[BEAT_W] ? '1 : b_wide[BEAT_W-1:0];
        ovf    = s_wide[CNT_W] | b_wide[BEAT_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid   <= 1'b0;
            p_cnt     <= '0;
            p_last    <= 1'b0;
            acc       <= '0;
            beats     <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_beats <= '0;
            out_sat   <= 1'b0;
        end else begin
            // A result load below overrides this clear, so back-to-back frames never bubble.
            if (out_fire) out_valid <= 1'b0;
            if (flush) begin
                p_valid <= 1'b0;
                acc     <= '0;
                beats   <= '0;
                sat     <= 1'b0;
            end else begin
                if (!stall) begin
                    p_valid <= in_fire;
                    if (in_fire) begin
                        p_cnt  <= beat_cnt;
                        p_last <= bus.in_last;
                    end
                end
                if (p_adv) begin
                    if (p_last) begin
                        out_sum   <= s_sat;
                        out_beats <= b_sat;
                        out_sat   <= sat | ovf;
                        out_valid <= 1'b1;
                        acc       <= '0;
                        beats     <= '0;
                        sat       <= 1'b0;
                    end else begin
                        acc   <= s_sat;
                        beats <= b_sat;
                        sat   <= sat | ovf;
                    end
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = out_sum;
    assign bus.out_beats = out_beats;
    assign bus.out_sat   = out_sat;
endmodule

// File: tb/tb_gpc_popcount_accum.sv
// Directed bench for gpc_popcount_accum with IN_W=32, CNT_W=8, BEAT_W=8.
// Inputs driven and outputs sampled on the falling clock edge.
// Result side is mostly held ready; specific steps drop out_ready to build backpressure.
module tb_gpc_popcount_accum;
    logic clk;
    logic rst;
    logic flush;
    int   n_vec;
    int   n_err;

    gpc_popcount_accum_if #(.IN_W(32), .CNT_W(8), .BEAT_W(8)) bus ();

    gpc_popcount_accum #(.IN_W(32), .CNT_W(8), .BEAT_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] vld, input logic [31:0] sum,
                           input logic [31:0] bts, input logic [31:0] st);
        chk({tag, ".valid"}, {31'd0, bus.out_valid}, vld);
        chk({tag, ".sum"},   {24'd0, bus.out_sum},   sum);
        chk({tag, ".beats"}, {24'd0, bus.out_beats}, bts);
        chk({tag, ".sat"},   {31'd0, bus.out_sat},   st);
    endtask

    // Present one beat for one clock; it must be accepted at the next rising edge.
    task automatic beat(input string tag, input logic [31:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] pc_tab [16];
        pc_tab = '{4'd1, 4'd1, 4'd2, 4'd1, 4'd2, 4'd2, 4'd3, 4'd1,
                   4'd2, 4'd2, 4'd3, 4'd2, 4'd3, 4'd3, 4'd4, 4'd1};
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_out("reset", 0, 0, 0, 0);
        chk("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // T1: 32 + 4 + 1 = 37 over 3 beats; result exactly two edges after the last beat edge
        beat("t1.b0", 32'hFFFF_FFFF, 1'b0);
        beat("t1.b1", 32'h0000_000F, 1'b0);
        beat("t1.b2", 32'h0000_0001, 1'b1);
        chk("t1.lat1", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk_out("t1", 1, 37, 3, 0);
        @(negedge clk);
        chk("t1.drain", {31'd0, bus.out_valid}, 32'd0);

        // T2: 9 x 32 = 288 saturates at 255; the following frame starts with sat clear
        for (int k = 0; k < 9; k++) beat("t2.b", 32'hFFFF_FFFF, (k == 8));
        @(negedge clk);
        chk_out("t2.sat", 1, 255, 9, 1);
        beat("t2.next", 32'h0000_0003, 1'b1);
        @(negedge clk);
        chk_out("t2.clr", 1, 2, 1, 0);
        @(negedge clk);

        // T3: held result (4) blocks frame B (8) in stage P; release drains 4 then 8
        bus.out_ready = 1'b0;
        beat("t3.a", 32'h0000_000F, 1'b1);
        beat("t3.b", 32'h0000_00FF, 1'b1);
        chk_out("t3.hold", 1, 4, 1, 0);
        chk("t3.in_ready0", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        chk("t3.held_sum", {24'd0, bus.out_sum}, 32'd4);
        chk("t3.in_ready1", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        chk("t3.first", {24'd0, bus.out_sum}, 32'd4);
        @(negedge clk);
        chk_out("t3.second", 1, 8, 1, 0);
        @(negedge clk);
        chk("t3.drain", {31'd0, bus.out_valid}, 32'd0);

        // T4: 16 single-beat frames back to back, one result per clock, no bubbles
        for (int k = 1; k <= 17; k++) begin
            bus.in_valid = (k <= 16);
            bus.in_data  = 32'(k);
            bus.in_last  = 1'b1;
            if (k <= 16) chk("t4.in_ready", {31'd0, bus.in_ready}, 32'd1);
            @(negedge clk);
            if (k >= 2) begin
                chk("t4.valid", {31'd0, bus.out_valid}, 32'd1);
                chk("t4.sum", {24'd0, bus.out_sum}, {28'd0, pc_tab[k-2]});
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t4.drain", {31'd0, bus.out_valid}, 32'd0);

        // T5: flush drops the partial frame and the beat offered with it
        beat("t5.b0", 32'h0000_00FF, 1'b0);
        beat("t5.b1", 32'h0000_00FF, 1'b0);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_00AA;
        bus.in_last  = 1'b0;
        chk("t5.in_ready_flush", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("t5.no_out", {31'd0, bus.out_valid}, 32'd0);
        beat("t5.b2", 32'h0000_0007, 1'b1);
        @(negedge clk);
        chk_out("t5", 1, 3, 1, 0);
        @(negedge clk);

        // T6: async reset between edges clears a pending result and a partial frame at once
        bus.out_ready = 1'b0;
        beat("t6.a", 32'h0000_0005, 1'b1);
        @(negedge clk);
        chk_out("t6.pend", 1, 2, 1, 0);
        beat("t6.part", 32'h0000_000F, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_out("t6.rst", 0, 0, 0, 0);
        @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        beat("t6.new", 32'h0000_0001, 1'b1);
        @(negedge clk);
        chk_out("t6.new", 1, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
